// File: rtl/uart_status_tx.sv
// Formats game-event status messages (START / OVER / SCORE) and hands them byte by byte
// to the shared uart transmit port. States: IDLE pick msg | SEND strobe byte | ARM wait uart busy | DRAIN wait uart idle | GAP post-message pause
module uart_status_tx #(
  parameter int GAP_TICKS = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             game_start,
  input  logic             game_over,
  input  logic             score_inc,
  input  logic [15:0]      score,
  input  logic             is_transmitting,
  output logic             transmit,
  output logic [7:0]       tx_byte,
  output logic             busy,
  output logic [CNT_W-1:0] sent_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEND  = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [1:0] M_START = 2'd0;
  localparam logic [1:0] M_OVER  = 2'd1;
  localparam logic [1:0] M_SCORE = 2'd2;

  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_TICKS > 0) ? GAP_W'(GAP_TICKS - 1) : '0;

  logic [2:0]       state;
  logic [1:0]       msg_sel;
  logic [15:0]      snap;
  logic [3:0]       idx;
  logic [3:0]       last_idx;
  logic [7:0]       msg_byte;
  logic [7:0]       tx_last;
  logic [GAP_W-1:0] gap_cnt;
  logic             p_start, p_over, p_score;
  logic             sel_go, clr_start, clr_over, clr_score;

  function automatic logic [7:0] asc(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  always_comb begin
    msg_byte = 8'h0A;
    last_idx = 4'd0;
    case (msg_sel)
      M_START: begin
        last_idx = 4'd6;
        case (idx)
          4'd0:    msg_byte = "S";
          4'd1:    msg_byte = "T";
          4'd2:    msg_byte = "A";
          4'd3:    msg_byte = "R";
          4'd4:    msg_byte = "T";
          4'd5:    msg_byte = 8'h0D;
          default: msg_byte = 8'h0A;
        endcase
      end
      M_OVER: begin
        last_idx = 4'd10;
        case (idx)
          4'd0:    msg_byte = "O";
          4'd1:    msg_byte = "V";
          4'd2:    msg_byte = "E";
          4'd3:    msg_byte = "R";
          4'd4:    msg_byte = " ";
          4'd5:    msg_byte = asc(snap[15:12]);
          4'd6:    msg_byte = asc(snap[11:8]);
          4'd7:    msg_byte = asc(snap[7:4]);
          4'd8:    msg_byte = asc(snap[3:0]);
          4'd9:    msg_byte = 8'h0D;
          default: msg_byte = 8'h0A;
        endcase
      end
      default: begin
        last_idx = 4'd11;
        case (idx)
          4'd0:    msg_byte = "S";
          4'd1:    msg_byte = "C";
          4'd2:    msg_byte = "O";
          4'd3:    msg_byte = "R";
          4'd4:    msg_byte = "E";
          4'd5:    msg_byte = " ";
          4'd6:    msg_byte = asc(snap[15:12]);
          4'd7:    msg_byte = asc(snap[11:8]);
          4'd8:    msg_byte = asc(snap[7:4]);
          4'd9:    msg_byte = asc(snap[3:0]);
          4'd10:   msg_byte = 8'h0D;
          default: msg_byte = 8'h0A;
        endcase
      end
    endcase
  end

  // Selecting START also discards a pending score report.
  assign sel_go    = (state == S_IDLE) && (p_over || p_start || p_score);
  assign clr_over  = sel_go && p_over;
  assign clr_start = sel_go && !p_over && p_start;
  assign clr_score = sel_go && !p_over;

  assign transmit = (state == S_SEND) && !is_transmitting;
  assign tx_byte  = transmit ? msg_byte : tx_last;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      msg_sel    <= M_START;
      snap       <= '0;
      idx        <= '0;
      tx_last    <= '0;
      gap_cnt    <= '0;
      sent_count <= '0;
      p_start    <= 1'b0;
      p_over     <= 1'b0;
      p_score    <= 1'b0;
    end else begin
      p_start <= (p_start && !clr_start) || game_start;
      p_over  <= (p_over && !clr_over) || game_over;
      p_score <= (p_score && !clr_score) || score_inc;
      case (state)
        S_IDLE: begin
          if (sel_go) begin
            snap  <= score;
            idx   <= '0;
            state <= S_SEND;
            if (p_over)       msg_sel <= M_OVER;
            else if (p_start) msg_sel <= M_START;
            else              msg_sel <= M_SCORE;
          end
        end
        S_SEND: begin
          if (!is_transmitting) begin
            tx_last <= msg_byte;
            state   <= S_ARM;
          end
        end
        S_ARM: begin
          if (is_transmitting) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!is_transmitting) begin
            if (idx == last_idx) begin
              sent_count <= sent_count + 1'b1;
              if (GAP_TICKS > 0) begin
                gap_cnt <= GAP_LOAD;
                state   <= S_GAP;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              idx   <= idx + 1'b1;
              state <= S_SEND;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) state <= S_IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
